fetch_unit: RTL and testbench

//  Instruction-fetch producer stage of the 5-stage RV32I pipeline: owns the fetch PC and drives the instruction-memory request/response port.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: owns fetch PC, issues imem requests, queues returned words in order.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect target becomes a flagged NOP entry on misalign_o.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   pc_q    [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   outstanding;
  logic [AW:0]   kill;
  logic [AW+1:0] inflight;
  logic [31:0]   target;
  logic          target_mis;
  logic          halted;
  logic          head_mis;
  logic          head_valid;
  logic          fire;
  logic          live_rsp;
  logic          pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic          mis_q [FIFO_DEPTH];

  assign target     = redirect_pc;
  assign target_mis = (redirect_pc[1:0] != 2'b00);
  assign head_mis   = head_valid && mis_q[rd_ptr];
  assign misalign_o = head_mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (redirect_i) begin
      halted <= target_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (redirect_i) begin
      mis_q[0] <= target_mis;
    end else if (live_rsp) begin
      mis_q[wr_ptr] <= 1'b0;
    end
  end
`else
  logic unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];
  assign target      = {redirect_pc[31:2], 2'b00};
  assign target_mis  = 1'b0;
  assign halted      = 1'b0;
  assign head_mis    = 1'b0;
`endif

  // Credit counts both in-flight requests (including ones to be killed) and buffered entries,
  // so a returning word always has a free slot.
  assign inflight   = (AW+2)'(outstanding) + (AW+2)'(count);
  assign imem_req   = rst && !redirect_i && !halted && (inflight < DEPTH_W);
  assign imem_addr  = fetch_pc;
  assign fire       = imem_req && imem_gnt;
  assign live_rsp   = imem_rvalid && (kill == '0) && !redirect_i;
  assign head_valid = (count != '0);
  assign pop        = head_valid && !stall_i && !redirect_i;

  assign instr_valid_o = head_valid;
  assign instr_o       = (head_valid && !head_mis) ? instr_q[rd_ptr] : NOP;
  assign pc_o          = head_valid ? pc_q[rd_ptr] : 32'd0;
  assign pc_plus4_o    = head_valid ? pc_q[rd_ptr] + 32'd4 : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      kill        <= '0;
    end else begin
      if (fire && !imem_rvalid) begin
        outstanding <= outstanding + CNT_ONE;
      end else if (!fire && imem_rvalid) begin
        outstanding <= outstanding - CNT_ONE;
      end

      if (redirect_i) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        resp_pc  <= target;
        rd_ptr   <= '0;
        kill     <= imem_rvalid ? outstanding - CNT_ONE : outstanding;
        wr_ptr   <= target_mis ? PTR_ONE : '0;
        count    <= target_mis ? CNT_ONE : '0;
      end else begin
        if (imem_rvalid && (kill != '0)) begin
          kill <= kill - CNT_ONE;
        end
        if (fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (live_rsp) begin
          wr_ptr  <= wr_ptr + PTR_ONE;
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (live_rsp && !pop) begin
          count <= count + CNT_ONE;
        end else if (!live_rsp && pop) begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

  // Responses are in order, so the live word's PC is simply the next sequential address since the last redirect.
  always_ff @(posedge clk) begin
    if (redirect_i) begin
      instr_q[0] <= NOP;
      pc_q[0]    <= target;
    end else if (live_rsp) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= resp_pc;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (!(live_rsp && !pop && (count == CNT_MAX)));
      assert (!(imem_rvalid && (outstanding == '0)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue-based fetch model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_i(redirect_i), .redirect_pc(redirect_pc), .stall_i(stall_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .instr_valid_o(instr_valid_o)
`ifdef FETCH_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ready; bit killed; } req_t;
  typedef struct { logic [31:0] pc; bit mis; } ent_t;

  req_t        pend[$];
  ent_t        q[$];
  logic [31:0] popped[$];
  logic [31:0] next_fetch = RESET_PC;
  bit          halted = 1'b0;
  int          cyc = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic drive_mem();
    imem_gnt = (int'($urandom_range(99)) < gnt_pct);
    if (pend.size() != 0 && pend[0].ready <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // One clock: compare DUT against the model at negedge, advance the model across the edge, drive memory after it.
  task automatic step();
    bit          exp_req;
    bit          do_pop;
    req_t        r;
    logic [31:0] tgt;
    @(negedge clk);
    exp_req = !redirect_i && !halted && (pend.size() + q.size() < DEPTH);
    n_checks++;
    if (imem_req !== exp_req) $display("FAIL req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req);
    else n_pass++;
    if (exp_req) begin
      n_checks++;
      if (imem_addr !== next_fetch) $display("FAIL addr cyc=%0d got=%h want=%h", cyc, imem_addr, next_fetch);
      else n_pass++;
    end
    n_checks++;
    if (instr_valid_o !== (q.size() != 0)) $display("FAIL valid cyc=%0d got=%b want=%b", cyc, instr_valid_o, q.size() != 0);
    else n_pass++;
    if (q.size() != 0) begin
      n_checks++;
      if (pc_o !== q[0].pc || pc_plus4_o !== q[0].pc + 32'd4 || instr_o !== (q[0].mis ? NOP : mem_word(q[0].pc)))
        $display("FAIL head cyc=%0d got pc=%h pc4=%h instr=%h want pc=%h pc4=%h instr=%h", cyc, pc_o, pc_plus4_o,
                 instr_o, q[0].pc, q[0].pc + 32'd4, q[0].mis ? NOP : mem_word(q[0].pc));
      else n_pass++;
    end else begin
      n_checks++;
      if (pc_o !== 32'd0 || pc_plus4_o !== 32'd0 || instr_o !== NOP)
        $display("FAIL empty cyc=%0d got pc=%h pc4=%h instr=%h want 0/0/%h", cyc, pc_o, pc_plus4_o, instr_o, NOP);
      else n_pass++;
    end
`ifdef FETCH_MISALIGN_CHK_EN
    n_checks++;
    if (misalign_o !== (q.size() != 0 && q[0].mis)) $display("FAIL misalign cyc=%0d got=%b", cyc, misalign_o);
    else n_pass++;
`endif
    do_pop = (q.size() != 0) && !stall_i && !redirect_i;
    if (imem_rvalid) r = pend.pop_front();
    if (redirect_i) begin
      foreach (pend[i]) pend[i].killed = 1'b1;
      q.delete();
      tgt    = redirect_pc;
      halted = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (tgt[1:0] != 2'b00) begin
        q.push_back('{pc: tgt, mis: 1'b1});
        halted = 1'b1;
      end
`else
      tgt[1:0] = 2'b00;
`endif
      next_fetch = tgt;
    end else begin
      if (do_pop) begin
        popped.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (imem_rvalid && !r.killed) q.push_back('{pc: r.addr, mis: 1'b0});
      if (exp_req && imem_gnt) begin
        pend.push_back('{addr: next_fetch, ready: cyc + 1 + int'($urandom_range(lat_max, lat_min)), killed: 1'b0});
        next_fetch = next_fetch + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    redirect_i = 1'b0;
    stall_i = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    pend.delete();
    q.delete();
    popped.delete();
    next_fetch = RESET_PC;
    halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_mem();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_i  = 1'b1;
    redirect_pc = target;
    step();
    redirect_i  = 1'b0;
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    repeat (7) step();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid_o !== 1'b0) $display("FAIL reset_ctl got req=%b valid=%b want 0/0", imem_req, instr_valid_o);
    else n_pass++;
    n_checks++;
    if (instr_o !== NOP || pc_o !== 32'd0 || pc_plus4_o !== 32'd0)
      $display("FAIL reset_data got instr=%h pc=%h pc4=%h want %h/0/0", instr_o, pc_o, pc_plus4_o, NOP);
    else n_pass++;
    n_checks++;
    if (imem_addr !== RESET_PC) $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC);
    else n_pass++;
    reset_dut();
  endtask

  task automatic test_stream();
    reset_dut();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (40) step();
    n_checks++;
    if (popped.size() < 20) $display("FAIL stream_rate got=%0d want>=20", popped.size());
    else n_pass++;
    foreach (popped[i]) begin
      n_checks++;
      if (popped[i] !== RESET_PC + 32'(4 * i)) $display("FAIL stream_pc idx=%0d got=%h want=%h", i, popped[i], RESET_PC + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] head;
    reset_dut();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (5) step();
    stall_i = 1'b1;
    step();
    head = pc_o;
    repeat (5) begin
      step();
      n_checks++;
      if (pc_o !== head || instr_valid_o !== 1'b1) $display("FAIL stall_hold got pc=%h valid=%b want pc=%h valid=1", pc_o, instr_valid_o, head);
      else n_pass++;
    end
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL stall_credit got req=%b want 0", imem_req);
    else n_pass++;
    stall_i = 1'b0;
    repeat (20) step();
    foreach (popped[i]) begin
      n_checks++;
      if (popped[i] !== RESET_PC + 32'(4 * i)) $display("FAIL stall_seq idx=%0d got=%h want=%h", i, popped[i], RESET_PC + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    int n;
    reset_dut();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    n = 0;
    while (pend.size() < 2 && n < 20) begin step(); n++; end
    n_checks++;
    if (pend.size() != 2) $display("FAIL redirect_setup outstanding got=%0d want=2", pend.size());
    else n_pass++;
    do_redirect(32'h0000_0100);
    popped.delete();
    n = 0;
    while (instr_valid_o !== 1'b1 && n < 30) begin step(); n++; end
    n_checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== mem_word(32'h100))
      $display("FAIL redirect_first got valid=%b pc=%h instr=%h want 1/%h/%h", instr_valid_o, pc_o, instr_o, 32'h100, mem_word(32'h100));
    else n_pass++;
  endtask

  task automatic test_wrap();
    reset_dut();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (3) step();
    do_redirect(32'hFFFF_FFFC);
    popped.delete();
    repeat (10) step();
    n_checks++;
    if (popped.size() < 2 || popped[0] !== 32'hFFFF_FFFC || popped[1] !== 32'h0000_0000)
      $display("FAIL wrap got n=%0d first=%h second=%h want FFFFFFFC then 00000000", popped.size(),
               popped.size() > 0 ? popped[0] : 32'hx, popped.size() > 1 ? popped[1] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] t;
    reset_dut();
    gnt_pct = 50; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 500; i++) begin
      stall_i = ($urandom_range(9) < 3);
      if ($urandom_range(99) < 3) begin
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(1) == 1) t = 32'hFFFF_FFF0 | (t & 32'hC);
        do_redirect(t);
      end else begin
        step();
      end
    end
    stall_i = 1'b0;
    n_checks++;
    if (popped.size() < 50) $display("FAIL random_progress got=%0d want>=50", popped.size());
    else n_pass++;
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    int n;
    reset_dut();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    repeat (4) step();
    stall_i = 1'b1;
    do_redirect(32'h0000_0102);
    repeat (3) begin
      step();
      n_checks++;
      if (misalign_o !== 1'b1 || pc_o !== 32'h102 || instr_o !== NOP || imem_req !== 1'b0)
        $display("FAIL misalign_hold got mis=%b pc=%h instr=%h req=%b", misalign_o, pc_o, instr_o, imem_req);
      else n_pass++;
    end
    stall_i = 1'b0;
    repeat (5) begin
      step();
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid_o !== 1'b0) $display("FAIL misalign_halt got req=%b valid=%b want 0/0", imem_req, instr_valid_o);
      else n_pass++;
    end
    do_redirect(32'h0000_0200);
    n = 0;
    while (instr_valid_o !== 1'b1 && n < 20) begin step(); n++; end
    n_checks++;
    if (pc_o !== 32'h200 || misalign_o !== 1'b0) $display("FAIL misalign_resume got pc=%h mis=%b want 200/0", pc_o, misalign_o);
    else n_pass++;
  endtask
`else
  task automatic test_misalign();
    int n;
    reset_dut();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    repeat (4) step();
    do_redirect(32'h0000_0103);
    n = 0;
    while (instr_valid_o !== 1'b1 && n < 20) begin step(); n++; end
    n_checks++;
    if (pc_o !== 32'h100 || instr_o !== mem_word(32'h100)) $display("FAIL lsb_force got pc=%h instr=%h want 100/%h", pc_o, instr_o, mem_word(32'h100));
    else n_pass++;
  endtask
`endif

  initial begin
    reset_dut();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
